uart_csr_bridge: RTL and testbench

- Byte-stream command bridge sitting directly upstream of the accelerator CSR block.
- Parses framed host commands from the UART receiver and issues single-cycle CSR write/read strobes.
- Returns acknowledgements and read data to the UART transmitter.
- Raises the CRC-error and illegal-command event pulses that the CSR block records as sticky status.

---
 rtl/uart_csr_bridge.sv | 174 +++++++++++++++++
 tb/tb_uart_csr_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_bridge.sv
// UART byte-stream to CSR bridge: parses A5/CMD/ADDR/[DATA]/CRC frames, issues one CSR strobe, returns ACK/NAK/read data.
// Optional frame statistics counters are built when UART_CSR_BRIDGE_STATS_EN is defined.
module uart_csr_bridge #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              crc_en,
    output logic              csr_wen,
    output logic              csr_ren,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_rdata,
    output logic              rx_crc_error,
    output logic              rx_illegal_cmd,
`ifdef UART_CSR_BRIDGE_STATS_EN
    output logic [15:0]       stat_ok_frames,
    output logic [15:0]       stat_bad_frames,
`endif
    output logic              bridge_busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] ACK = 8'h5A;
    localparam logic [7:0] NAK = 8'hEE;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CRC, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        is_write;
    logic [7:0]  crc_acc;
    logic [1:0]  byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [47:0] tx_sh;
    logic [2:0]  tx_cnt;
    logic        in_frame, tmo_hit, illegal_nxt, crc_err_nxt;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    function automatic logic [7:0] crc8_word(input logic [31:0] w);
        return crc8_upd(crc8_upd(crc8_upd(crc8_upd(8'h00, w[7:0]), w[15:8]), w[23:16]), w[31:24]);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        crc_err_nxt = 1'b0;
        tmo_hit     = 1'b0;
        in_frame    = (state == CMD) || (state == ADDR) || (state == DATA) || (state == CRC);
        case (state)
            IDLE: if (rx_valid && rx_data == SOF) state_nxt = CMD;
            CMD: if (rx_valid) begin
                if (rx_data == 8'h01 || rx_data == 8'h02) state_nxt = ADDR;
                else begin
                    illegal_nxt = 1'b1;
                    state_nxt   = RESP;
                end
            end
            ADDR: if (rx_valid) state_nxt = is_write ? DATA : CRC;
            DATA: if (rx_valid && byte_cnt == 2'd3) state_nxt = CRC;
            CRC: if (rx_valid) begin
                if (crc_en && rx_data != crc_acc) begin
                    crc_err_nxt = 1'b1;
                    state_nxt   = RESP;
                end else state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (tx_ready && tx_cnt == 3'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A stalled frame is abandoned without a response.
        if (in_frame && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_write       <= 1'b0;
            crc_acc        <= 8'h00;
            byte_cnt       <= 2'd0;
            tmo_cnt        <= '0;
            tx_sh          <= '0;
            tx_cnt         <= 3'd0;
            csr_addr       <= '0;
            csr_wdata      <= '0;
            rx_crc_error   <= 1'b0;
            rx_illegal_cmd <= 1'b0;
        end else begin
            rx_illegal_cmd <= illegal_nxt | tmo_hit;
            rx_crc_error   <= crc_err_nxt;
            if (in_frame && !rx_valid && !tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
            else                                   tmo_cnt <= '0;
            case (state)
                IDLE: begin
                    crc_acc  <= 8'h00;
                    byte_cnt <= 2'd0;
                end
                CMD: if (rx_valid) begin
                    crc_acc  <= crc8_upd(crc_acc, rx_data);
                    is_write <= (rx_data == 8'h01);
                    if (illegal_nxt) begin
                        tx_sh  <= {40'h0, NAK};
                        tx_cnt <= 3'd1;
                    end
                end
                ADDR: if (rx_valid) begin
                    crc_acc  <= crc8_upd(crc_acc, rx_data);
                    csr_addr <= rx_data[ADDR_W-1:0];
                end
                DATA: if (rx_valid) begin
                    crc_acc                          <= crc8_upd(crc_acc, rx_data);
                    csr_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
                    byte_cnt                         <= byte_cnt + 2'd1;
                end
                CRC: if (crc_err_nxt) begin
                    tx_sh  <= {40'h0, NAK};
                    tx_cnt <= 3'd1;
                end
                EXEC: begin
                    if (is_write) begin
                        tx_sh  <= {40'h0, ACK};
                        tx_cnt <= 3'd1;
                    end else begin
                        tx_sh  <= {crc8_word(csr_rdata), csr_rdata, ACK};
                        tx_cnt <= 3'd6;
                    end
                end
                RESP: if (tx_ready) begin
                    tx_sh  <= {8'h00, tx_sh[47:8]};
                    tx_cnt <= tx_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign csr_wen     = (state == EXEC) && is_write;
    assign csr_ren     = (state == EXEC) && !is_write;
    assign tx_valid    = (state == RESP);
    assign tx_data     = tx_sh[7:0];
    assign bridge_busy = (state != IDLE);

`ifdef UART_CSR_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ok_frames  <= 16'h0;
            stat_bad_frames <= 16'h0;
        end else begin
            if (state == EXEC && stat_ok_frames != 16'hFFFF)
                stat_ok_frames <= stat_ok_frames + 16'h1;
            if ((crc_err_nxt || illegal_nxt || tmo_hit) && stat_bad_frames != 16'hFFFF)
                stat_bad_frames <= stat_bad_frames + 16'h1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: write, read, CRC error, garbage, timeout, backpressure and mid-frame reset.
module tb_uart_csr_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        crc_en = 1'b1;
    logic        csr_wen, csr_ren;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata = 32'h0;
    logic        rx_crc_error, rx_illegal_cmd, bridge_busy;

    int checks = 0;
    int failures = 0;
    int wen_cnt, ren_cnt, both_cnt, crcerr_cnt, ill_cnt;
    logic [7:0]  last_addr;
    logic [31:0] last_wdata;
    logic [7:0]  txq[$];
    logic [7:0]  expq[$];

    uart_csr_bridge #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .crc_en(crc_en),
        .csr_wen(csr_wen), .csr_ren(csr_ren), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .rx_crc_error(rx_crc_error), .rx_illegal_cmd(rx_illegal_cmd),
        .bridge_busy(bridge_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_wen) begin
            wen_cnt++;
            last_addr  = csr_addr;
            last_wdata = csr_wdata;
        end
        if (csr_ren) begin
            ren_cnt++;
            last_addr = csr_addr;
        end
        if (csr_wen && csr_ren) both_cnt++;
        if (rx_crc_error) crcerr_cnt++;
        if (rx_illegal_cmd) ill_cnt++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wen_cnt = 0; ren_cnt = 0; crcerr_cnt = 0; ill_cnt = 0;
        txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk) #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk) #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bridge_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 200), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_txq(input string tag);
        check({tag, "_len"}, 64'(txq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(txq[i]), 64'(expq[i]));
    endtask

    task automatic send_write(input logic [7:0] crc);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        send_byte(8'h2A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(crc);
    endtask

    initial begin
        logic [7:0] held;
        int unstable;
        both_cnt = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {tx_valid, csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, bridge_busy}, 64'd0);
        check("rst_addr_wdata", {csr_addr, csr_wdata}, 64'd0);
        rst_n = 1'b1;

        // Write frame, CRC of 01 04 2A 00 00 00 is F4.
        clear_mon();
        send_write(8'hF4);
        check("wr_latency_wen", 64'(csr_wen), 64'd1);
        wait_idle("wr_idle");
        check("wr_wen_cnt", 64'(wen_cnt), 64'd1);
        check("wr_ren_cnt", 64'(ren_cnt), 64'd0);
        check("wr_addr", 64'(last_addr), 64'h04);
        check("wr_wdata", 64'(last_wdata), 64'h2A);
        expq = '{8'h5A};
        check_txq("wr_tx");
        check("wr_busy_after", 64'(bridge_busy), 64'd0);
        check("wr_hold_wdata", 64'(csr_wdata), 64'h2A);

        // Read frame, CRC of 02 3C is 9E; response CRC of 02 01 00 00 is 47.
        clear_mon();
        csr_rdata = 32'h0000_0102;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h9E);
        check("rd_latency_ren", 64'(csr_ren), 64'd1);
        wait_idle("rd_idle");
        check("rd_ren_cnt", 64'(ren_cnt), 64'd1);
        check("rd_wen_cnt", 64'(wen_cnt), 64'd0);
        check("rd_addr", 64'(last_addr), 64'h3C);
        expq = '{8'h5A, 8'h02, 8'h01, 8'h00, 8'h00, 8'h47};
        check_txq("rd_tx");

        // Bad CRC with checking on, then ignored.
        clear_mon();
        crc_en = 1'b1;
        send_write(8'hF4 ^ 8'hFF);
        wait_idle("badcrc_idle");
        check("badcrc_pulse", 64'(crcerr_cnt), 64'd1);
        check("badcrc_wen", 64'(wen_cnt), 64'd0);
        expq = '{8'hEE};
        check_txq("badcrc_tx");
        clear_mon();
        crc_en = 1'b0;
        send_write(8'hF4 ^ 8'hFF);
        wait_idle("nocrc_idle");
        check("nocrc_wen", 64'(wen_cnt), 64'd1);
        check("nocrc_crcerr", 64'(crcerr_cnt), 64'd0);
        expq = '{8'h5A};
        check_txq("nocrc_tx");
        crc_en = 1'b1;

        // Garbage then illegal opcode.
        clear_mon();
        send_byte(8'h00); send_byte(8'hFF);
        check("garbage_busy", 64'(bridge_busy), 64'd0);
        send_byte(8'hA5); send_byte(8'h07);
        wait_idle("ill_idle");
        check("ill_pulse", 64'(ill_cnt), 64'd1);
        check("ill_strobes", 64'(wen_cnt + ren_cnt), 64'd0);
        expq = '{8'hEE};
        check_txq("ill_tx");

        // Inter-byte timeout, then a normal frame.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01);
        repeat (20) @(negedge clk);
        check("tmo_pulse", 64'(ill_cnt), 64'd1);
        check("tmo_busy", 64'(bridge_busy), 64'd0);
        check("tmo_tx_len", 64'(txq.size()), 64'd0);
        check("tmo_wen", 64'(wen_cnt), 64'd0);
        clear_mon();
        send_write(8'hF4);
        wait_idle("post_tmo_idle");
        check("post_tmo_wen", 64'(wen_cnt), 64'd1);
        expq = '{8'h5A};
        check_txq("post_tmo_tx");

        // Backpressure on a read response.
        clear_mon();
        tx_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h9E);
        begin
            int n = 0;
            while (tx_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_tx_valid", 64'(tx_valid), 64'd1);
        end
        held = tx_data;
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_data !== held || tx_valid !== 1'b1) unstable++;
        end
        check("bp_first_byte", 64'(held), 64'h5A);
        check("bp_stable", 64'(unstable), 64'd0);
        @(posedge clk) #1;
        tx_ready = 1'b1;
        wait_idle("bp_idle");
        expq = '{8'h5A, 8'h02, 8'h01, 8'h00, 8'h00, 8'h47};
        check_txq("bp_tx");

        // Reset after the ADDR byte; the rest of the frame is garbage.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
        rst_n = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        check("mid_rst_outputs", {tx_valid, csr_wen, csr_ren, rx_crc_error, rx_illegal_cmd, bridge_busy}, 64'd0);
        check("mid_rst_addr_wdata", {csr_addr, csr_wdata}, 64'd0);
        send_byte(8'h2A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF4);
        repeat (5) @(negedge clk);
        check("mid_rst_strobes", 64'(wen_cnt + ren_cnt), 64'd0);
        check("mid_rst_pulses", 64'(ill_cnt + crcerr_cnt), 64'd0);
        check("mid_rst_tx_len", 64'(txq.size()), 64'd0);
        check("mid_rst_busy", 64'(bridge_busy), 64'd0);
        check("never_both_strobes", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
